// File: rtl/score_sequencer_pkg.sv
// Shared definitions for the score sequencer: FSM encodings and the result-bus
// layout (done flag sits directly above the winning index).
package score_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DONE_BIT_DEFAULT   = DEFAULT_DATA_WIDTH;

    // The done flag is the MSB of a result bus that is one bit wider than the data.
    function automatic int done_bit_pos(input int data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/score_sequencer_buffer.sv
// Frame storage: DEPTH x DATA_WIDTH, one synchronous write port, one
// combinational read port. Contents are never reset; every entry is rewritten per frame.
module score_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_dat,
    input  logic [AW-1:0]         i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_dat
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/score_sequencer.sv
// Collects N scores, streams them one per cycle starting the cycle after the N-th accept,
// then captures the argmax result and holds it until result_ready; in_ready only in FILL.
module score_sequencer
    import score_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int WEIGHT_AMOUNT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_value,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] output_index,
    output logic [DATA_WIDTH-1:0] output_value,
    output logic                  output_enable,
    input  logic [DATA_WIDTH:0]   result_in,
    output logic [DATA_WIDTH-1:0] result_index,
    output logic                  result_valid,
    input  logic                  result_ready
);

    localparam int            CW       = $clog2(WEIGHT_AMOUNT);
    localparam logic [CW-1:0] LAST     = CW'(WEIGHT_AMOUNT - 1);
    localparam int            DONE_BIT = done_bit_pos(DATA_WIDTH);

    state_t                r_state;
    logic [CW-1:0]         r_fill_cnt;
    logic [CW-1:0]         r_strm_cnt;
    logic [DATA_WIDTH-1:0] r_result_index;
    logic                  r_result_valid;

    logic                  w_in_fire;
    logic                  w_streaming;
    logic [DATA_WIDTH-1:0] w_rd_dat;

    assign w_in_fire   = in_valid && (r_state == ST_FILL);
    assign w_streaming = (r_state == ST_STREAM);

    score_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (WEIGHT_AMOUNT),
        .AW         (CW)
    ) u_buffer (
        .clk       (clk),
        .i_wr_en   (w_in_fire),
        .i_wr_addr (r_fill_cnt),
        .i_wr_dat  (in_value),
        .i_rd_addr (r_strm_cnt),
        .o_rd_dat  (w_rd_dat)
    );

    // Outputs decode registered state only, so the stream appears on the first
    // cycle after the N-th accept and drops the instant reset asserts.
    assign in_ready      = (r_state == ST_FILL);
    assign output_enable = w_streaming;
    assign output_index  = w_streaming ? DATA_WIDTH'(r_strm_cnt) : '0;
    assign output_value  = w_streaming ? w_rd_dat : '0;
    assign result_index  = r_result_index;
    assign result_valid  = r_result_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_FILL;
            r_fill_cnt     <= '0;
            r_strm_cnt     <= '0;
            r_result_index <= '0;
            r_result_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_in_fire) begin
                        if (r_fill_cnt == LAST) begin
                            r_fill_cnt <= '0;
                            r_state    <= ST_STREAM;
                        end else begin
                            r_fill_cnt <= r_fill_cnt + CW'(1);
                        end
                    end
                end
                ST_STREAM: begin
                    if (r_strm_cnt == LAST) begin
                        r_strm_cnt <= '0;
                        r_state    <= ST_WAIT;
                    end else begin
                        r_strm_cnt <= r_strm_cnt + CW'(1);
                    end
                end
                ST_WAIT: begin
                    if (result_in[DONE_BIT]) begin
                        r_result_index <= result_in[DATA_WIDTH-1:0];
                        r_result_valid <= 1'b1;
                        r_state        <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (r_result_valid && result_ready) begin
                        r_result_valid <= 1'b0;
                        r_state        <= ST_FILL;
                    end
                end
                default: r_state <= ST_FILL;
            endcase
        end
    end

endmodule

// File: doc/score_sequencer.md
SCORE_SEQUENCER -- requirements
Module: score_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of score values and indices.
REQ-002 Parameter WEIGHT_AMOUNT, default 4: scores per frame (N); SHALL be >= 2.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 in_value  input  DATA_WIDTH  unsigned score from the producing layer.
REQ-006 in_valid  input  1  in_value valid this cycle.
REQ-007 in_ready  output  1  block accepts a score this cycle; a beat transfers when in_valid & in_ready.
REQ-008 output_index  output  DATA_WIDTH  index of the streamed score, 0..N-1.
REQ-009 output_value  output  DATA_WIDTH  streamed score.
REQ-010 output_enable  output  1  output_index/output_value valid this cycle.
REQ-011 result_in  input  DATA_WIDTH+1  argmax stage result; bit DATA_WIDTH = done flag, low bits = winning index.
REQ-012 result_index  output  DATA_WIDTH  captured winning index.
REQ-013 result_valid  output  1  result_index valid; held until accepted.
REQ-014 result_ready  input  1  downstream accepts result when result_valid & result_ready.

Function
REQ-015 FSM states: FILL, STREAM, WAIT, HOLD; reset state FILL.
REQ-016 FILL: in_ready=1; each transfer writes in_value to buffer[count] and increments count; gaps in in_valid stall without loss.
REQ-017 On the N-th transfer: count clears, FSM moves to STREAM on the next edge; in_ready=0 in all states other than FILL.
REQ-018 STREAM: one element per cycle, output_enable=1, output_index = counter, output_value = buffer[counter], index 0 first, contiguous, no bubbles, N cycles exactly.
REQ-019 First STREAM cycle SHALL be the cycle immediately after the edge that accepted the N-th score.
REQ-020 After index N-1 is driven, FSM moves to WAIT; output_enable=0, output_index=0, output_value=0 in every non-STREAM state.
REQ-021 WAIT: when result_in[DATA_WIDTH]=1, register result_in[DATA_WIDTH-1:0] into result_index, set result_valid, move to HOLD; expected on the first WAIT cycle (argmax registered one cycle after the last element).
REQ-022 result_in is ignored in FILL, STREAM and HOLD, including a set done flag.
REQ-023 HOLD: result_valid=1, result_index stable; on result_valid & result_ready, clear result_valid, move to FILL on the same edge.
REQ-024 Buffer contents are not cleared between frames; every entry is rewritten in FILL before use.
REQ-025 Counters are $clog2(WEIGHT_AMOUNT) bits; output_index zero-extends the counter to DATA_WIDTH.
REQ-026 Minimum frame period = N (fill) + N (stream) + 1 (wait) + 1 (hold) cycles.

Reset
REQ-027 rst=1 asynchronously forces FILL, counters 0, output_enable=0, output_index=0, output_value=0, result_valid=0, result_index=0, in_ready=1 once rst=0.
REQ-028 Reset during STREAM or WAIT aborts the frame; no partial stream resumes, and a later done flag is ignored until the next WAIT.
REQ-029 Buffer storage need not be reset.

Structure
REQ-030 Shared package: FSM state encodings (FILL=0, STREAM=1, WAIT=2, HOLD=3) and the done-flag bit position constant.
REQ-031 One sub-module score_buffer (N x DATA_WIDTH, one write port, one combinational read port); FSM and counters in score_sequencer.

Verification
REQ-032 N=4, scores 5,9,2,7 back-to-back, argmax model -> stream (0,5),(1,9),(2,2),(3,7) on four consecutive cycles; result_index=1, result_valid next cycle.
REQ-033 Fill with in_valid gaps (1,0,1,0,1,1) -> exactly 4 scores captured in order; STREAM starts the cycle after the 4th transfer.
REQ-034 result_ready low 5 cycles in HOLD -> result_valid/result_index stable, in_ready=0, output_enable=0; accepted on cycle 6, FILL next.
REQ-035 Done flag driven high during FILL and STREAM -> no capture; result_valid stays 0.
REQ-036 rst pulsed on the 2nd STREAM cycle -> output_enable=0 immediately, FSM FILL, next frame streams from index 0.
REQ-037 Two frames back-to-back (5,9,2,7 then 8,1,1,3) -> results 1 then 0; no data from frame 1 leaks into frame 2.
